// File: rtl/multi_edge_detector.sv
// Per-channel edge detector: input synchronizer, edge pulse and saturating event counter.
// Define MULTI_EDGE_DEBOUNCE_EN to insert a DB_CYCLES stability filter between synchronizer and detector.
`timescale 1ns/1ps
module multi_edge_detector #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        L,
  input  logic [2*N_CH-1:0]      mode,
  input  logic                   clr_cnt,
  output logic [N_CH-1:0]        P,
  output logic                   any_P,
  output logic [N_CH*CNT_W-1:0]  cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (N_CH < 1 || N_CH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DB_CYCLES < 2 || DB_CYCLES > 255 || CNT_W < 1 || CNT_W > 16) begin : g_param_check
    $error("multi_edge_detector: parameter out of range");
  end

  logic [N_CH-1:0]  sync_r [SYNC_STAGES];
  logic [N_CH-1:0]  s;
  logic [N_CH-1:0]  det;
  logic [N_CH-1:0]  d_r;
  logic [N_CH-1:0]  p_next;
  logic [N_CH-1:0]  p_r;
  logic             any_r;
  logic [CNT_W-1:0] cnt_r [N_CH];

  // Synchronizer chain for the asynchronous level inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= '0;
      end
    end else begin
      sync_r[0] <= L;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign s = sync_r[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DEBOUNCE_EN
  logic [N_CH-1:0] f_r;
  logic [7:0]      db_cnt_r [N_CH];

  // Filter follows s only after it has disagreed for DB_CYCLES consecutive edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_r <= '0;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt_r[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (s[i] == f_r[i]) begin
          db_cnt_r[i] <= 8'd0;
        end else if (db_cnt_r[i] == 8'(DB_CYCLES - 1)) begin
          f_r[i]      <= s[i];
          db_cnt_r[i] <= 8'd0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + 8'd1;
        end
      end
    end
  end

  assign det = f_r;
`else
  assign det = s;
`endif

  // Rise/fall event decode gated by each channel's two mode bits.
  always_comb begin
    p_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      p_next[i] = (mode[2*i]   &  det[i] & ~d_r[i]) |
                  (mode[2*i+1] & ~det[i] &  d_r[i]);
    end
  end

  // Previous-value register tracks det every cycle so mode changes never see stale history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_r   <= '0;
      p_r   <= '0;
      any_r <= 1'b0;
    end else begin
      d_r   <= det;
      p_r   <= p_next;
      any_r <= |p_next;
    end
  end

  // Saturating event counters; clear has priority over a coincident pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (clr_cnt) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (p_r[i] && (cnt_r[i] != CNT_MAX)) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
    assign cnt[g*CNT_W +: CNT_W] = cnt_r[g];
  end

  assign P     = p_r;
  assign any_P = any_r;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector: stimulus pushes expected pulses, a forked monitor pops and compares.
`timescale 1ns/1ps
module tb_multi_edge_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  L;
  logic [7:0]  mode;
  logic        clr_cnt;
  logic [3:0]  P;
  logic        any_P;
  logic [31:0] cnt;

  typedef struct {
    int         cyc;
    logic [3:0] p;
  } exp_t;

  exp_t sb[$];
  int   edge_no  = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   any_hi   = 0;

  multi_edge_detector #(
    .N_CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .L(L), .mode(mode), .clr_cnt(clr_cnt),
    .P(P), .any_P(any_P), .cnt(cnt)
  );

  always #10 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  function automatic logic [31:0] cnt_of(int i);
    return 32'(cnt[i*8 +: 8]);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, edge_no);
    end
  endtask

  // Expected pulse appears lat edges after the current one.
  task automatic push_exp(int lat, logic [3:0] p);
    exp_t e;
    e.cyc = edge_no + lat;
    e.p   = p;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (P != 4'h0 || any_P)) begin
        if (any_P) any_hi++;
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_pulse: P=%b any_P=%b at edge %0d, expected no pulse", P, any_P, edge_no);
        end else begin
          e = sb.pop_front();
          if (e.cyc != edge_no || e.p != P || any_P != (e.p != 4'h0)) begin
            n_errors++;
            $display("FAIL sb_pulse: P=%b any_P=%b at edge %0d, expected P=%b any_P=%b at edge %0d",
                     P, any_P, edge_no, e.p, (e.p != 4'h0), e.cyc);
          end
        end
      end
    end
  endtask

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    reset = 1'b0; L = 4'h0; mode = 8'h00; clr_cnt = 1'b0;
    fork monitor(); join_none
    wait_n(3);
    chk("reset_P", 32'(P), 32'h0);
    chk("reset_any_P", 32'(any_P), 32'h0);
    chk("reset_cnt", cnt, 32'h0);
    mode = 8'h55; reset = 1'b1;
    wait_n(2);
`ifdef MULTI_EDGE_DEBOUNCE_EN
    L = 4'h1; wait_n(2); L = 4'h0;
    wait_n(12);
    chk("db_glitch_cnt0", cnt_of(0), 32'd0);
    L = 4'h1; push_exp(7, 4'h1);
    wait_n(10);
    chk("db_level_cnt0", cnt_of(0), 32'd1);
    L = 4'h0; wait_n(10);
`else
    // Rise-only: one pulse on the 0->1, none on the fall.
    L = 4'h1; push_exp(3, 4'h1);
    wait_n(3);
    L = 4'h0;
    wait_n(6);
    chk("rise_cnt0", cnt_of(0), 32'd1);
    chk("rise_cnt1", cnt_of(1), 32'd0);

    // Both edges on all channels simultaneously.
    mode = 8'hFF; a0 = any_hi;
    L = 4'hF; push_exp(3, 4'hF);
    wait_n(3);
    L = 4'h0; push_exp(3, 4'hF);
    wait_n(6);
    chk("both_any_P_cycles", 32'(any_hi - a0), 32'd2);
    chk("both_cnt0", cnt_of(0), 32'd3);
    chk("both_cnt1", cnt_of(1), 32'd2);
    chk("both_cnt3", cnt_of(3), 32'd2);

    clr_cnt = 1'b1; wait_n(1); clr_cnt = 1'b0;
    chk("clr_all", cnt, 32'h0);

    // Channel 1 fall only; channel 2 off while toggling.
    mode = 8'h08;
    L = 4'b0010; wait_n(3);
    L = 4'b0000; push_exp(3, 4'b0010);
    wait_n(3);
    for (int t = 0; t < 3; t++) begin
      L = 4'b0100; wait_n(3);
      L = 4'b0000; wait_n(3);
    end
    wait_n(3);
    chk("fall_cnt1", cnt_of(1), 32'd1);
    chk("off_cnt2", cnt_of(2), 32'd0);

    // Saturation on channel 3.
    mode = 8'h40;
    for (int j = 0; j < 256; j++) begin
      L = 4'h8; push_exp(3, 4'h8);
      wait_n(2);
      L = 4'h0;
      wait_n(2);
    end
    wait_n(4);
    chk("sat_cnt3", cnt_of(3), 32'd255);

    // Clear coincident with a P[3] pulse wins.
    L = 4'h8; push_exp(3, 4'h8);
    wait_n(3);
    clr_cnt = 1'b1; wait_n(1); clr_cnt = 1'b0;
    chk("clr_vs_pulse_cnt3", cnt_of(3), 32'd0);
    L = 4'h0; wait_n(3);
    L = 4'h8; push_exp(3, 4'h8);
    wait_n(5);
    chk("post_clr_cnt3", cnt_of(3), 32'd1);
    L = 4'h0; wait_n(3);

    // Level held high through reset reads as a rise after release.
    mode = 8'h01;
    L = 4'h1; reset = 1'b0;
    wait_n(2);
    chk("in_reset_P", 32'(P), 32'h0);
    chk("in_reset_cnt", cnt, 32'h0);
    reset = 1'b1; push_exp(3, 4'h1);
    wait_n(5);
    chk("release_cnt0", cnt_of(0), 32'd1);

    // Reset mid-pulse drops P at once.
    L = 4'h0; wait_n(3);
    L = 4'h1; push_exp(3, 4'h1);
    wait_n(3);
    #5 reset = 1'b0;
    #1;
    chk("reset_mid_P", 32'(P), 32'h0);
    chk("reset_mid_any_P", 32'(any_P), 32'h0);
    chk("reset_mid_cnt", cnt, 32'h0);
    L = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    wait_n(6);
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
